// File: rtl/table_fsm_if.sv
// Control/config bus of the table-driven state machine.
// The master drives the step and table-write inputs; the slave (the FSM) returns state and flags.
interface table_fsm_if #(
  parameter int STATE_W = 2,
  parameter int IN_W    = 3,
  parameter int OUT_W   = 3
);
  logic                      en;
  logic [IN_W-1:0]           x;
  logic                      cfg_we;
  logic [STATE_W+IN_W-1:0]   cfg_addr;
  logic [STATE_W-1:0]        cfg_next;
  logic [OUT_W-1:0]          cfg_out;
  logic                      cfg_clr;
  logic [STATE_W-1:0]        state;
  logic [OUT_W-1:0]          z;
  logic                      chg;
  logic                      err;

  modport master (
    output en, x, cfg_we, cfg_addr, cfg_next, cfg_out, cfg_clr,
    input  state, z, chg, err
  );

  modport slave (
    input  en, x, cfg_we, cfg_addr, cfg_next, cfg_out, cfg_clr,
    output state, z, chg, err
  );
endinterface

// File: rtl/table_fsm.sv
// Run-time programmable FSM: next state and outputs come from a writable table indexed
// by {state, x}. Unprogrammed entries send the machine back to RESET_STATE and set a sticky err.
module table_fsm #(
  parameter int STATE_W     = 2,
  parameter int IN_W        = 3,
  parameter int OUT_W       = 3,
  parameter int RESET_STATE = 0
) (
  input  logic        clk,
  input  logic        rst,
  table_fsm_if.slave  bus
);
  localparam int ADDR_W  = STATE_W + IN_W;
  localparam int ENTRIES = 1 << ADDR_W;
  localparam logic [STATE_W-1:0] RST_ST = STATE_W'(RESET_STATE);

  // Table data fields are not reset; only the valid bits are.
  logic [STATE_W-1:0] next_mem [ENTRIES];
  logic [OUT_W-1:0]   out_mem  [ENTRIES];

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [OUT_W-1:0]   z_q, z_d;
  logic               chg_q, chg_d;
  logic               err_q, err_d;

  logic               wr_en;
  logic [ADDR_W-1:0]  idx;
  logic               hit_valid;
  logic [STATE_W-1:0] ent_next;
  logic [OUT_W-1:0]   ent_out;

  assign wr_en = bus.cfg_we && !bus.cfg_clr;

  // Read-before-write: the step uses the entry as it stood before this edge.
  assign idx       = {state_q, bus.x};
  assign hit_valid = valid_q[idx];
  assign ent_next  = next_mem[idx];
  assign ent_out   = out_mem[idx];

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      next_mem[bus.cfg_addr] <= bus.cfg_next;
      out_mem[bus.cfg_addr]  <= bus.cfg_out;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_valid
      assign valid_d[gi] = bus.cfg_clr ? 1'b0
                         : (valid_q[gi] || (wr_en && (bus.cfg_addr == ADDR_W'(gi))));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    chg_d   = 1'b0;
    err_d   = bus.cfg_clr ? 1'b0 : err_q;
    if (bus.en) begin
      if (hit_valid) begin
        state_d = ent_next;
        z_d     = ent_out;
        chg_d   = (ent_next != state_q);
      end else begin
        // Invalid hit wins over a same-edge cfg_clr.
        state_d = RST_ST;
        z_d     = '0;
        chg_d   = (state_q != RST_ST);
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      state_q <= RST_ST;
      z_q     <= '0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      z_q     <= z_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

  assign bus.state = state_q;
  assign bus.z     = z_q;
  assign bus.chg   = chg_q;
  assign bus.err   = err_q;
endmodule
